// File: rtl/multicycle_ctrl_if.sv
// Datapath control bundle between multicycle_ctrl and the shared datapath.
//
// master (controller) sees:
//   command      5  decoded command of the instruction held in IR
//   zero         1  ALU equality flag, meaningful in EXEC
//   dmem_ack     1  data memory completion
// and drives:
//   pc_write     1  PC load strobe
//   pc_src       2  0 PC+4, 1 branch target, 2 jump target, 3 GRF[rs]
//   ir_write     1  IR load strobe
//   ALUop        4  0 add, 1 sub, 2 or
//   operand_type 4  0 reg, 1 zero-ext imm, 2 sign-ext imm
//   GRF_write    4  write-back source: 0 ALU, 1 DM, 2 PC+4, 3 lui imm
//   reg_write    1  GRF write strobe
//   dmem_req     1  data memory request
//   mem_write    1  store qualifier, valid with dmem_req
// slave (datapath) takes the mirrored directions.

interface multicycle_ctrl_if;
    logic [4:0] command;
    logic       zero;
    logic       dmem_ack;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic [3:0] ALUop;
    logic [3:0] operand_type;
    logic [3:0] GRF_write;
    logic       reg_write;
    logic       dmem_req;
    logic       mem_write;

    modport master (
        input  command, zero, dmem_ack,
        output pc_write, pc_src, ir_write, ALUop, operand_type,
               GRF_write, reg_write, dmem_req, mem_write
    );

    modport slave (
        output command, zero, dmem_ack,
        input  pc_write, pc_src, ir_write, ALUop, operand_type,
               GRF_write, reg_write, dmem_req, mem_write
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing controller for the MIPS-subset datapath.
// Steps PC/IR/ALU/GRF/DM through FETCH/DECODE/EXEC/MEM/WB, runs the
// data-memory req/ack handshake with a bounded wait, and counts retired
// instructions.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   run      in   level; leave IDLE / keep fetching while high
//   dp       --   datapath control bundle (master side)
//   illegal  out  one-cycle pulse when DECODE sees an illegal command
//   timeout  out  sticky; set when MEM waits too long for dmem_ack
//   busy     out  high in every state except IDLE
//   retired  out  count of completed instructions, wraps
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | stopped, all strobes low, waiting for run
// FETCH  | load IR from PC, PC <= PC+4
// DECODE | latch command into cmd_q; nop/jr/illegal finish here
// EXEC   | ALU operates on cmd_q operands; beq resolves here
// MEM    | dmem request held until ack or wait limit
// WB     | single-cycle GRF write (and jal jump)

module multicycle_ctrl #(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    multicycle_ctrl_if.master dp,
    output logic             illegal,
    output logic             timeout,
    output logic             busy,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    localparam logic [4:0] CMD_NOP = 5'd0;
    localparam logic [4:0] CMD_ADD = 5'd1;
    localparam logic [4:0] CMD_SUB = 5'd2;
    localparam logic [4:0] CMD_ORI = 5'd3;
    localparam logic [4:0] CMD_LW  = 5'd4;
    localparam logic [4:0] CMD_SW  = 5'd5;
    localparam logic [4:0] CMD_BEQ = 5'd6;
    localparam logic [4:0] CMD_JAL = 5'd7;
    localparam logic [4:0] CMD_JR  = 5'd8;
    localparam logic [4:0] CMD_LUI = 5'd9;

    localparam logic [1:0] PC_SRC_SEQ = 2'd0;
    localparam logic [1:0] PC_SRC_BR  = 2'd1;
    localparam logic [1:0] PC_SRC_J   = 2'd2;
    localparam logic [1:0] PC_SRC_RS  = 2'd3;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_OR  = 4'd2;

    localparam logic [3:0] OPND_REG  = 4'd0;
    localparam logic [3:0] OPND_ZEXT = 4'd1;
    localparam logic [3:0] OPND_SEXT = 4'd2;

    localparam logic [3:0] WB_ALU = 4'd0;
    localparam logic [3:0] WB_DM  = 4'd1;
    localparam logic [3:0] WB_PC4 = 4'd2;
    localparam logic [3:0] WB_LUI = 4'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         cmd_q, cmd_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   retired_q;
    logic               timeout_q;
    logic               retire;
    logic               timeout_set;
    state_t             end_state;

    logic               pc_write_c;
    logic [1:0]         pc_src_c;
    logic               ir_write_c;
    logic [3:0]         alu_op_c;
    logic [3:0]         operand_type_c;
    logic [3:0]         grf_write_c;
    logic               reg_write_c;
    logic               dmem_req_c;
    logic               mem_write_c;
    logic               illegal_c;

    // run is only consulted where an instruction finishes, so an
    // instruction already in flight always completes.
    assign end_state = run ? S_FETCH : S_IDLE;

    // ------------------------------------------------------------------
    // State register and the small amount of datapath state it owns
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cmd_q     <= 5'd0;
            wait_q    <= '0;
            retired_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            wait_q  <= wait_d;
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        wait_d      = wait_q;
        retire      = 1'b0;
        timeout_set = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                state_d = S_DECODE;
            end

            S_DECODE: begin
                cmd_d = dp.command;
                case (dp.command)
                    CMD_NOP, CMD_JR: begin
                        retire  = 1'b1;
                        state_d = end_state;
                    end
                    CMD_JAL: begin
                        state_d = S_WB;
                    end
                    CMD_ADD, CMD_SUB, CMD_ORI, CMD_LW,
                    CMD_SW, CMD_BEQ, CMD_LUI: begin
                        state_d = S_EXEC;
                    end
                    default: begin
                        // illegal: dropped without retiring
                        state_d = end_state;
                    end
                endcase
            end

            S_EXEC: begin
                case (cmd_q)
                    CMD_ADD, CMD_SUB, CMD_ORI, CMD_LUI: state_d = S_WB;
                    CMD_LW, CMD_SW:                     state_d = S_MEM;
                    CMD_BEQ: begin
                        retire  = 1'b1;
                        state_d = end_state;
                    end
                    default:                            state_d = end_state;
                endcase
            end

            S_MEM: begin
                // ack takes priority over the wait limit in the same cycle
                if (dp.dmem_ack) begin
                    wait_d = '0;
                    if (cmd_q == CMD_LW) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = end_state;
                    end
                end else if (wait_q == WAIT_W'(MAX_WAIT)) begin
                    timeout_set = 1'b1;
                    wait_d      = '0;
                    state_d     = S_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            S_WB: begin
                retire  = 1'b1;
                state_d = end_state;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode. Everything is a function of state_q and cmd_q, so
    // an async reset forces IDLE and every strobe drops with it. DECODE
    // is the exception: cmd_q is only being loaded there, so jr and the
    // illegal pulse decode the command currently sitting in IR.
    // ------------------------------------------------------------------
    always_comb begin
        pc_write_c     = 1'b0;
        pc_src_c       = PC_SRC_SEQ;
        ir_write_c     = 1'b0;
        alu_op_c       = ALU_ADD;
        operand_type_c = OPND_REG;
        grf_write_c    = WB_ALU;
        reg_write_c    = 1'b0;
        dmem_req_c     = 1'b0;
        mem_write_c    = 1'b0;
        illegal_c      = 1'b0;

        case (state_q)
            S_FETCH: begin
                ir_write_c = 1'b1;
                pc_write_c = 1'b1;
                pc_src_c   = PC_SRC_SEQ;
            end

            S_DECODE: begin
                if (dp.command == CMD_JR) begin
                    pc_write_c = 1'b1;
                    pc_src_c   = PC_SRC_RS;
                end
                illegal_c = (dp.command > CMD_LUI);
            end

            S_EXEC: begin
                case (cmd_q)
                    CMD_ADD: begin
                        alu_op_c       = ALU_ADD;
                        operand_type_c = OPND_REG;
                    end
                    CMD_SUB: begin
                        alu_op_c       = ALU_SUB;
                        operand_type_c = OPND_REG;
                    end
                    CMD_ORI: begin
                        alu_op_c       = ALU_OR;
                        operand_type_c = OPND_ZEXT;
                    end
                    CMD_LW, CMD_SW: begin
                        alu_op_c       = ALU_ADD;
                        operand_type_c = OPND_SEXT;
                    end
                    CMD_BEQ: begin
                        alu_op_c       = ALU_SUB;
                        operand_type_c = OPND_REG;
                        pc_write_c     = dp.zero;
                        pc_src_c       = PC_SRC_BR;
                    end
                    default: begin
                    end
                endcase
            end

            S_MEM: begin
                // address computation stays on the ALU for the whole access
                alu_op_c       = ALU_ADD;
                operand_type_c = OPND_SEXT;
                dmem_req_c     = 1'b1;
                mem_write_c    = (cmd_q == CMD_SW);
            end

            S_WB: begin
                reg_write_c = 1'b1;
                case (cmd_q)
                    CMD_LW:  grf_write_c = WB_DM;
                    CMD_JAL: begin
                        grf_write_c = WB_PC4;
                        pc_write_c  = 1'b1;
                        pc_src_c    = PC_SRC_J;
                    end
                    CMD_LUI: grf_write_c = WB_LUI;
                    default: grf_write_c = WB_ALU;
                endcase
            end

            default: begin
            end
        endcase
    end

    assign dp.pc_write     = pc_write_c;
    assign dp.pc_src       = pc_src_c;
    assign dp.ir_write     = ir_write_c;
    assign dp.ALUop        = alu_op_c;
    assign dp.operand_type = operand_type_c;
    assign dp.GRF_write    = grf_write_c;
    assign dp.reg_write    = reg_write_c;
    assign dp.dmem_req     = dmem_req_c;
    assign dp.mem_write    = mem_write_c;

    assign illegal = illegal_c;
    assign timeout = timeout_q;
    assign busy    = (state_q != S_IDLE);
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
    localparam int CNT_W    = 32;
    localparam int MAX_WAIT = 15;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             run = 1'b0;
    logic             illegal;
    logic             timeout;
    logic             busy;
    logic [CNT_W-1:0] retired;

    multicycle_ctrl_if dp ();

    multicycle_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (run),
        .dp      (dp),
        .illegal (illegal),
        .timeout (timeout),
        .busy    (busy),
        .retired (retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic [3:0] alu_op;
        logic [3:0] opnd;
        logic [3:0] grf;
        logic       reg_write;
        logic       dmem_req;
        logic       mem_write;
        logic       illegal;
        logic       busy;
    } outs_t;

    // one clock cycle of expected behaviour plus the inputs to apply in it
    typedef struct {
        outs_t      o;
        logic       run;
        logic [4:0] cmd;
        logic       zero;
        logic       ack;
        bit         retire;
        bit         to_set;
    } step_t;

    step_t            steps[$];
    int               tests = 0;
    int               fails = 0;
    int               cyc = 0;
    logic [CNT_W-1:0] exp_ret = '0;
    logic             exp_to = 1'b0;

    function automatic logic [4:0] n5();
        return 5'($urandom_range(0, 31));
    endfunction

    function automatic logic n1();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic outs_t active();
        outs_t o = '0;
        o.busy = 1'b1;
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.pc_write  = dp.pc_write;
        o.pc_src    = dp.pc_src;
        o.ir_write  = dp.ir_write;
        o.alu_op    = dp.ALUop;
        o.opnd      = dp.operand_type;
        o.grf       = dp.GRF_write;
        o.reg_write = dp.reg_write;
        o.dmem_req  = dp.dmem_req;
        o.mem_write = dp.mem_write;
        o.illegal   = illegal;
        o.busy      = busy;
        return o;
    endfunction

    function automatic void push(input outs_t o, input logic r, input logic [4:0] c,
                                 input logic z, input logic a, input bit ret, input bit tos);
        step_t s;
        s.o = o; s.run = r; s.cmd = c; s.zero = z; s.ack = a;
        s.retire = ret; s.to_set = tos;
        steps.push_back(s);
    endfunction

    // Reference model: expands one instruction into its cycle sequence.
    // d = cycles dmem_ack stays low in MEM; stop = run low from DECODE on.
    function automatic void build(input logic [4:0] cmd, input logic z, input int d, input bit stop);
        outs_t o;
        logic  rl;
        int    nw;
        bit    to;
        bit    has_wb;
        rl = stop ? 1'b0 : 1'b1;
        to = 0;

        o = active(); o.pc_write = 1; o.ir_write = 1;
        push(o, 1'b1, n5(), n1(), n1(), 0, 0);

        o = active();
        if (cmd >= 10) begin
            o.illegal = 1;
            push(o, rl, cmd, n1(), n1(), 0, 0);
        end else if (cmd == 0) begin
            push(o, rl, cmd, n1(), n1(), 1, 0);
        end else if (cmd == 8) begin
            o.pc_write = 1; o.pc_src = 3;
            push(o, rl, cmd, n1(), n1(), 1, 0);
        end else begin
            push(o, rl, cmd, n1(), n1(), 0, 0);
            if (cmd != 7) begin
                o = active();
                case (cmd)
                    2: o.alu_op = 1;
                    3: begin o.alu_op = 2; o.opnd = 1; end
                    4, 5: o.opnd = 2;
                    6: begin o.alu_op = 1; o.pc_write = z; o.pc_src = 1; end
                    default: ;
                endcase
                push(o, rl, n5(), (cmd == 6) ? z : n1(), n1(), cmd == 6, 0);
                if (cmd == 4 || cmd == 5) begin
                    nw = (d > MAX_WAIT) ? MAX_WAIT + 1 : d;
                    o = active(); o.opnd = 2; o.dmem_req = 1; o.mem_write = (cmd == 5);
                    for (int i = 0; i < nw; i++)
                        push(o, rl, n5(), n1(), 1'b0, 0, (d > MAX_WAIT) && (i == nw - 1));
                    if (d <= MAX_WAIT) push(o, rl, n5(), n1(), 1'b1, cmd == 5, 0);
                    else to = 1;
                end
            end
            has_wb = (cmd == 1 || cmd == 2 || cmd == 3 || cmd == 4 || cmd == 7 || cmd == 9);
            if (has_wb && !to) begin
                o = active(); o.reg_write = 1;
                o.grf = (cmd == 4) ? 4'd1 : (cmd == 7) ? 4'd2 : (cmd == 9) ? 4'd3 : 4'd0;
                if (cmd == 7) begin o.pc_write = 1; o.pc_src = 2; end
                push(o, rl, n5(), n1(), n1(), 1, 0);
            end
        end
        if (stop || to) push('0, 1'b1, n5(), n1(), n1(), 0, 0);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step_one(input step_t s);
        @(negedge clk);
        run = s.run; dp.command = s.cmd; dp.zero = s.zero; dp.dmem_ack = s.ack;
        #1;
        check($sformatf("outs@%0d", cyc), 64'(sample()), 64'(s.o));
        check($sformatf("retired@%0d", cyc), 64'(retired), 64'(exp_ret));
        check($sformatf("timeout@%0d", cyc), 64'(timeout), 64'(exp_to));
        if (s.retire) exp_ret = exp_ret + 1'b1;
        if (s.to_set) exp_to = 1'b1;
        cyc++;
    endtask

    task automatic run_all();
        while (steps.size() > 0) step_one(steps.pop_front());
    endtask

    initial begin
        step_t      s;
        int         r;
        int         d;
        logic [4:0] c;

        dp.command = 5'd0; dp.zero = 1'b0; dp.dmem_ack = 1'b0;
        #1;
        check("reset_outs", 64'(sample()), 64'(0));
        check("reset_retired", 64'(retired), 64'(0));
        check("reset_timeout", 64'(timeout), 64'(0));
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;

        push('0, 1'b0, n5(), n1(), n1(), 0, 0);   // IDLE holds while run low
        push('0, 1'b1, n5(), n1(), n1(), 0, 0);
        build(5'd1, 1'b0, 0, 0);                  // add
        build(5'd4, 1'b0, 3, 0);                  // lw, ack after 3
        build(5'd5, 1'b0, 0, 0);                  // sw, immediate ack
        build(5'd6, 1'b1, 0, 0);                  // beq taken
        build(5'd6, 1'b0, 0, 0);                  // beq not taken
        build(5'd7, 1'b0, 0, 0);                  // jal
        build(5'd8, 1'b0, 0, 0);                  // jr
        build(5'd12, 1'b0, 0, 0);                 // illegal
        build(5'd5, 1'b0, 16, 0);                 // sw timeout
        build(5'd4, 1'b0, MAX_WAIT, 0);           // ack exactly at the limit
        build(5'd0, 1'b0, 0, 0);
        build(5'd3, 1'b0, 0, 0);
        build(5'd2, 1'b0, 0, 0);
        build(5'd9, 1'b0, 0, 0);
        build(5'd4, 1'b0, 2, 1);                  // run dropped mid-lw
        run_all();

        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 15);
            c = (r >= 10) ? 5'($urandom_range(10, 31)) : 5'(r);
            d = ($urandom_range(0, 9) == 0) ? 16 + $urandom_range(0, 3) : $urandom_range(0, 4);
            build(c, n1(), d, $urandom_range(0, 9) == 0);
            run_all();
        end

        // async reset in the middle of a write-back
        build(5'd1, 1'b0, 0, 0);
        while (steps.size() > 1) step_one(steps.pop_front());
        s = steps.pop_front();
        @(negedge clk);
        run = s.run; dp.command = s.cmd; dp.zero = s.zero; dp.dmem_ack = s.ack;
        #1;
        check("wb_reg_write", 64'(dp.reg_write), 64'(1));
        reset_n = 1'b0;
        #1;
        check("rst_reg_write", 64'(dp.reg_write), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_retired", 64'(retired), 64'(0));
        check("rst_timeout", 64'(timeout), 64'(0));
        exp_ret = '0;
        exp_to  = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b1;
        push('0, 1'b1, n5(), n1(), n1(), 0, 0);
        build(5'd1, 1'b0, 0, 1);
        run_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencing controller for the MIPS-subset datapath.
- Takes the 5-bit decoded command of the instruction in the IR and steps the shared datapath (PC, IR, ALU, GRF, DM) through FETCH/DECODE/EXEC/MEM/WB.
- Handles a req/ack handshake with data memory, plus start/stop control and retired-instruction counting.
- Replaces the single-cycle control path; the datapath muxes keep their existing select encodings.

Parameters:
- CNT_W, 32, width of retired-instruction counter
- MAX_WAIT, 15, max cycles held in MEM without dmem_ack before timeout

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- run  in  1  level; controller leaves IDLE / continues fetching while high
- command  in  5  decoded command: 0 nop, 1 add, 2 sub, 3 ori, 4 lw, 5 sw, 6 beq, 7 jal, 8 jr, 9 lui; 10-31 illegal
- zero  in  1  ALU equality flag, valid in EXEC
- dmem_ack  in  1  data memory completion, sampled in MEM
- pc_write  out  1  PC load strobe
- pc_src  out  2  0 PC+4, 1 branch target, 2 jump target, 3 GRF[rs]
- ir_write  out  1  IR load strobe
- ALUop  out  4  0 add, 1 sub, 2 or
- operand_type  out  4  0 reg, 1 zero-ext imm, 2 sign-ext imm
- GRF_write  out  4  write-back source: 0 ALU, 1 DM, 2 PC+4, 3 lui imm
- reg_write  out  1  GRF write strobe
- dmem_req  out  1  data memory request
- mem_write  out  1  store qualifier, valid with dmem_req
- illegal  out  1  one-cycle pulse on illegal command
- timeout  out  1  sticky, set on MEM wait overrun
- busy  out  1  high in any state except IDLE
- retired  out  CNT_W  count of completed instructions

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB.
- Reset (async, reset_n low):
  - state=IDLE; cmd_q=0; wait_cnt=0; retired=0; timeout=0.
  - All strobes 0; pc_src, ALUop, operand_type, GRF_write = 0.
- Strobes are decoded from state and cmd_q only. They must never glitch high in IDLE.
- cmd_q is latched from command in DECODE; EXEC, MEM and WB use cmd_q, not command.
- IDLE: outputs 0, busy=0. Go to FETCH when run=1.
- FETCH: ir_write=1, pc_write=1, pc_src=0; go to DECODE.
- DECODE (cmd_q<=command):
  - nop: retire, go to FETCH.
  - jal: go to WB.
  - jr: pc_write=1, pc_src=3; retire; go to FETCH.
  - illegal: illegal=1; no retire; go to FETCH.
  - otherwise: go to EXEC.
- EXEC (ALU/operand controls held):
  - add: ALUop=0, operand_type=0; go to WB.
  - sub: ALUop=1, operand_type=0; go to WB.
  - ori: ALUop=2, operand_type=1; go to WB.
  - lui: go to WB.
  - lw, sw: ALUop=0, operand_type=2; go to MEM.
  - beq: ALUop=1, operand_type=0; pc_write=zero, pc_src=1; retire; go to FETCH.
- MEM:
  - dmem_req=1; mem_write=1 for sw only. ALU controls held as in EXEC.
  - wait_cnt increments each cycle without ack.
  - dmem_ack=1: clear wait_cnt. lw goes to WB. sw retires and goes to FETCH.
  - No ack and wait_cnt==MAX_WAIT: set timeout, clear wait_cnt, go to IDLE, no retire.
  - Ack in the same cycle as the limit: ack wins.
- WB: reg_write=1 for exactly one cycle; retire; go to FETCH. GRF_write by instruction:
  - add/sub/ori: 0
  - lw: 1
  - jal: 2; jal also asserts pc_write=1, pc_src=2 in this cycle
  - lui: 3
- Return to FETCH: if run=0 at that transition, go to IDLE instead. run is sampled only there, so an instruction in flight always completes.
- timeout clears only on reset. Controller may restart from IDLE while timeout=1.
- retired wraps modulo 2^CNT_W.
- reset_n asserted mid-instruction: immediate return to IDLE, all strobes drop asynchronously, no partial write.

Test Plan:
- Reset, run=1, add (cmd 1): strobes are IDLE→FETCH→DECODE→EXEC→WB, reg_write high 1 cycle with GRF_write=0, ALUop=0 in EXEC; retired=1 after 4 cycles post-IDLE.
- lw with dmem_ack delayed 3 cycles: dmem_req high 4 cycles, mem_write=0; then WB with GRF_write=1; sw with immediate ack: mem_write=1 1 cycle, no reg_write, retired+1.
- beq with zero=1 then zero=0: pc_write pulses in EXEC with pc_src=1 only for zero=1; both retire; neither asserts reg_write.
- jal then jr: jal WB has reg_write=1, GRF_write=2, pc_write=1, pc_src=2; jr DECODE has pc_write=1, pc_src=3, no reg_write.
- command=12 in DECODE: illegal pulses 1 cycle, retired unchanged, next state FETCH. sw with no ack for 16 cycles: timeout=1, state IDLE, busy=0.
- run dropped during MEM of lw: lw completes WB, then IDLE; reset_n pulsed low during WB: reg_write falls immediately, retired=0.
